// File: rtl/ertn_unit.sv
// Exception-return engine: drains memory, restores CRMD/LLBCTL/TLBRERA through
// the shared CSR write port, then redirects fetch to ERA or TLBRERA.
module ertn_unit #(
    parameter int          DRAIN_MAX   = 255,
    parameter logic [13:0] CSR_CRMD    = 14'h000,
    parameter logic [13:0] CSR_LLBCTL  = 14'h060,
    parameter logic [13:0] CSR_TLBRERA = 14'h08A
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ertn_valid,
    output logic        ertn_ready,
    input  logic        exc_req,
    input  logic        mem_idle,
    input  logic [31:0] csr_crmd,
    input  logic [31:0] csr_prmd,
    input  logic [31:0] csr_era,
    input  logic [31:0] csr_tlbrera,
    input  logic [31:0] csr_tlbrprmd,
    input  logic [31:0] csr_llbctl,
    output logic        flush,
    output logic        csr_we,
    output logic [13:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        llbit_clr,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        drain_timeout,
    output logic        busy
);

    localparam int CNT_W = (DRAIN_MAX < 2) ? 1 : $clog2(DRAIN_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DRAIN_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_WR_CRMD,
        S_WR_LLB,
        S_WR_TLBR,
        S_REDIRECT
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] drain_cnt;
    logic             accept;

    logic [31:0] crmd_q, prmd_q, era_q, tlbrera_q, tlbrprmd_q, llbctl_q;
    logic        tlbr_q;

    // Privilege level, IE and WE come back from PRMD; a TLB refill return
    // also forces mapped mode (DA=0, PG=1).
    function automatic logic [31:0] restore_crmd(input logic [31:0] crmd,
                                                 input logic [31:0] prmd,
                                                 input logic [31:0] tlbrprmd,
                                                 input logic        tlbr);
        logic [31:0] r;
        r = crmd;
        if (tlbr) begin
            r[2:0] = tlbrprmd[2:0];
            r[9]   = tlbrprmd[4];
            r[3]   = 1'b0;
            r[4]   = 1'b1;
        end else begin
            r[2:0] = prmd[2:0];
            r[9]   = prmd[3];
        end
        return r;
    endfunction

    function automatic logic [31:0] clear_bits(input logic [31:0] v, input logic [31:0] mask);
        return v & ~mask;
    endfunction

    assign accept = ertn_valid && (state == S_IDLE) && !exc_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
        end
    end

    // CSR snapshot taken at acceptance; these are data only and need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            crmd_q     <= csr_crmd;
            prmd_q     <= csr_prmd;
            era_q      <= csr_era;
            tlbrera_q  <= csr_tlbrera;
            tlbrprmd_q <= csr_tlbrprmd;
            llbctl_q   <= csr_llbctl;
            tlbr_q     <= csr_tlbrera[0];
        end
    end

    always_comb begin
        state_next     = state;
        ertn_ready     = 1'b0;
        busy           = (state != S_IDLE);
        flush          = (state != S_IDLE);
        csr_we         = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        llbit_clr      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        drain_timeout  = 1'b0;
        case (state)
            S_IDLE: begin
                ertn_ready = 1'b1;
                if (accept) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (exc_req) begin
                    state_next = S_IDLE;
                end else if (mem_idle) begin
                    state_next = S_WR_CRMD;
                end else if (drain_cnt == CNT_MAX) begin
                    drain_timeout = 1'b1;
                    state_next    = S_WR_CRMD;
                end
            end
            S_WR_CRMD: begin
                csr_we     = 1'b1;
                csr_waddr  = CSR_CRMD;
                csr_wdata  = restore_crmd(crmd_q, prmd_q, tlbrprmd_q, tlbr_q);
                state_next = S_WR_LLB;
            end
            S_WR_LLB: begin
                csr_we     = 1'b1;
                csr_waddr  = CSR_LLBCTL;
                csr_wdata  = clear_bits(llbctl_q, 32'h4);
                llbit_clr  = !llbctl_q[2];
                state_next = tlbr_q ? S_WR_TLBR : S_REDIRECT;
            end
            S_WR_TLBR: begin
                csr_we     = 1'b1;
                csr_waddr  = CSR_TLBRERA;
                csr_wdata  = clear_bits(tlbrera_q, 32'h1);
                state_next = S_REDIRECT;
            end
            S_REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = clear_bits(tlbr_q ? tlbrera_q : era_q, 32'h3);
                if (redirect_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ertn_unit.sv
// Scoreboard bench for ertn_unit: stimulus pushes expected CSR writes and
// redirects; a negedge monitor pops and compares them.
module tb_ertn_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ertn_valid, ertn_ready, exc_req, mem_idle;
    logic [31:0] csr_crmd, csr_prmd, csr_era, csr_tlbrera, csr_tlbrprmd, csr_llbctl;
    logic        flush, csr_we, llbit_clr, redirect_valid, redirect_ready, drain_timeout, busy;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wdata, redirect_pc;

    typedef struct {
        logic [13:0] addr;
        logic [31:0] data;
        logic        clr;
    } wr_t;

    wr_t         wq[$];
    logic [31:0] rq[$];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    ertn_unit #(.DRAIN_MAX(4)) dut (
        .clk(clk), .reset(reset), .ertn_valid(ertn_valid), .ertn_ready(ertn_ready),
        .exc_req(exc_req), .mem_idle(mem_idle),
        .csr_crmd(csr_crmd), .csr_prmd(csr_prmd), .csr_era(csr_era),
        .csr_tlbrera(csr_tlbrera), .csr_tlbrprmd(csr_tlbrprmd), .csr_llbctl(csr_llbctl),
        .flush(flush), .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .llbit_clr(llbit_clr), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .drain_timeout(drain_timeout), .busy(busy)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: architectural effect of one ERTN.
    task automatic push_expect(input logic [31:0] crmd, prmd, era, tlbrera, tlbrprmd, llb,
                               input bit reset_after_crmd);
        wr_t w;
        logic [31:0] c;
        bit tl;
        tl = tlbrera[0];
        c = crmd;
        if (tl) begin
            c[1:0] = tlbrprmd[1:0]; c[2] = tlbrprmd[2]; c[9] = tlbrprmd[4];
            c[3] = 1'b0; c[4] = 1'b1;
        end else begin
            c[1:0] = prmd[1:0]; c[2] = prmd[2]; c[9] = prmd[3];
        end
        w.addr = 14'h000; w.data = c; w.clr = 1'b0; wq.push_back(w);
        if (reset_after_crmd) return;
        w.addr = 14'h060; w.data = {llb[31:3], 1'b0, llb[1:0]}; w.clr = !llb[2]; wq.push_back(w);
        if (tl) begin
            w.addr = 14'h08A; w.data = {tlbrera[31:1], 1'b0}; w.clr = 1'b0; wq.push_back(w);
        end
        rq.push_back(tl ? {tlbrera[31:2], 2'b00} : {era[31:2], 2'b00});
    endtask

    initial begin : monitor
        bit          held = 0;
        logic [31:0] held_pc = '0;
        wr_t         w;
        forever begin
            @(negedge clk);
            if (csr_we === 1'b1) begin
                if (wq.size() == 0) check("unexpected_csr_write", {18'b0, csr_waddr}, 32'hFFFF_FFFF);
                else begin
                    w = wq.pop_front();
                    check("csr_waddr", {18'b0, csr_waddr}, {18'b0, w.addr});
                    check("csr_wdata", csr_wdata, w.data);
                    check("llbit_clr", {31'b0, llbit_clr}, {31'b0, w.clr});
                end
            end else if (llbit_clr === 1'b1) begin
                check("stray_llbit_clr", 32'd1, 32'd0);
            end
            if (redirect_valid === 1'b1 && held) check("redirect_pc_stable", redirect_pc, held_pc);
            if (redirect_valid === 1'b1 && redirect_ready === 1'b1) begin
                if (rq.size() == 0) check("unexpected_redirect", redirect_pc, 32'hFFFF_FFFF);
                else check("redirect_pc", redirect_pc, rq.pop_front());
            end
            held    = (redirect_valid === 1'b1) && (redirect_ready !== 1'b1);
            held_pc = redirect_pc;
        end
    end

    task automatic scramble();
        csr_crmd = $urandom; csr_prmd = $urandom; csr_era = $urandom;
        csr_tlbrera = $urandom; csr_tlbrprmd = $urandom; csr_llbctl = $urandom;
    endtask

    // k: DRAIN cycles with mem_idle=0; rr: REDIRECT cycles with redirect_ready=0;
    // abort: DRAIN cycle (1-based) in which exc_req pulses, 0 for none.
    task automatic run_ertn(input logic [31:0] crmd, prmd, era, tlbrera, tlbrprmd, llb,
                            input int k, input int rr, input int abort);
        bit tl;
        int drain, c, lat, tocnt, limit;
        bit seen;
        tl = tlbrera[0];
        drain = (k + 1 < 5) ? k + 1 : 5;
        @(posedge clk); #1;
        csr_crmd = crmd; csr_prmd = prmd; csr_era = era;
        csr_tlbrera = tlbrera; csr_tlbrprmd = tlbrprmd; csr_llbctl = llb;
        ertn_valid = 1'b1; redirect_ready = (rr == 0); mem_idle = 1'b0;
        #2 check("ready_before_accept", {31'b0, ertn_ready}, 32'd1);
        if (abort == 0) push_expect(crmd, prmd, era, tlbrera, tlbrprmd, llb, 1'b0);
        @(posedge clk); #1;
        ertn_valid = 1'b0;
        scramble();
        c = 1; seen = 0; lat = 0; tocnt = 0;
        limit = (abort != 0) ? abort + 4 : 60;
        while (c <= limit && !seen) begin
            mem_idle = (c > k);
            exc_req  = (c == abort);
            #2;
            if (drain_timeout === 1'b1) tocnt++;
            if (redirect_valid === 1'b1) begin
                seen = 1; lat = c;
            end else begin
                @(posedge clk); #1;
                c++;
            end
        end
        exc_req = 1'b0;
        if (abort != 0) begin
            check("abort_no_redirect", {31'b0, seen}, 32'd0);
            check("abort_idle", {31'b0, busy}, 32'd0);
            check("abort_ready", {31'b0, ertn_ready}, 32'd1);
            return;
        end
        check("redirect_seen", {31'b0, seen}, 32'd1);
        check("latency", lat, drain + 3 + int'(tl));
        check("timeout_pulses", tocnt, (k >= 5) ? 1 : 0);
        for (int h = 0; h < rr; h++) begin
            @(posedge clk); #3;
            check("redirect_held", {31'b0, redirect_valid}, 32'd1);
        end
        redirect_ready = 1'b1;
        @(posedge clk); #1;
        redirect_ready = 1'b0;
        #2;
        check("idle_after_redirect", {31'b0, busy}, 32'd0);
        check("ready_after_redirect", {31'b0, ertn_ready}, 32'd1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        reset = 1'b1; ertn_valid = 1'b0; exc_req = 1'b0; mem_idle = 1'b0;
        redirect_ready = 1'b0; scramble();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ertn_ready", {31'b0, ertn_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_flush", {31'b0, flush}, 32'd0);
        check("rst_csr_we", {31'b0, csr_we}, 32'd0);
        check("rst_csr_wdata", csr_wdata, 32'd0);
        check("rst_redirect", {31'b0, redirect_valid}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        reset = 1'b0;

        run_ertn(32'h8, 32'hF, 32'h1C000103, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        run_ertn(32'h8, 32'h0, 32'h0, 32'h80001005, 32'h13, 32'h0, 0, 0, 0);
        run_ertn(32'h8, 32'h3, 32'h1C000200, 32'h0, 32'h0, 32'h5, 0, 0, 0);
        run_ertn(32'h8, 32'h3, 32'h1C000300, 32'h0, 32'h0, 32'h0, 3, 0, 2);
        run_ertn(32'hB0, 32'h6, 32'h2000_0007, 32'h0, 32'h0, 32'h1, 10, 3, 0);

        // ERTN in the same cycle as an exception is not accepted
        @(posedge clk); #1;
        ertn_valid = 1'b1; exc_req = 1'b1;
        @(posedge clk); #1;
        ertn_valid = 1'b0; exc_req = 1'b0;
        #2 check("exc_blocks_accept", {31'b0, busy}, 32'd0);

        // Reset during WR_CRMD: only the CRMD write is seen
        @(posedge clk); #1;
        csr_crmd = 32'h8; csr_prmd = 32'h1; csr_era = 32'h1000; csr_tlbrera = 32'h0;
        csr_tlbrprmd = 32'h0; csr_llbctl = 32'h0;
        ertn_valid = 1'b1; mem_idle = 1'b1;
        push_expect(32'h8, 32'h1, 32'h1000, 32'h0, 32'h0, 32'h0, 1'b1);
        @(posedge clk); #1;
        ertn_valid = 1'b0;
        @(posedge clk); #2;
        check("wr_crmd_before_reset", {31'b0, csr_we}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #2;
        check("midrst_ertn_ready", {31'b0, ertn_ready}, 32'd1);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_csr_we", {31'b0, csr_we}, 32'd0);
        check("midrst_redirect", {31'b0, redirect_valid}, 32'd0);
        reset = 1'b0;
        repeat (5) @(posedge clk);

        for (int i = 0; i < 25; i++) begin
            run_ertn($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("write_queue_empty", wq.size(), 32'd0);
        check("redirect_queue_empty", rq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
